// File: rtl/uart_alu_if.sv
// Three-byte ALU front end between the Rx and Tx UARTs: A, B, opcode in; one result byte out.
// Optional inter-byte timeout is enabled by defining ALU_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int NB_BITS        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [1:0] {GET_A, GET_B, GET_OP, WAIT_TX} state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state_q, state_d;
  logic [NB_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [NB_BITS-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               err_q, err_d;

  logic [NB_OP-1:0]   opcode;
  logic [NB_BITS-1:0] alu_res;
  logic               op_ok;
  logic               shift_ovf;

  assign opcode    = i_data[NB_OP-1:0];
  assign shift_ovf = (32'(b_q) >= NB_BITS);

  always_comb begin
    alu_res = '0;
    op_ok   = 1'b1;
    case (opcode)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_SRA:  alu_res = shift_ovf ? {NB_BITS{a_q[NB_BITS-1]}}
                                   : $unsigned($signed(a_q) >>> b_q);
      OP_SRL:  alu_res = shift_ovf ? '0 : (a_q >> b_q);
      default: op_ok   = 1'b0;
    endcase
  end

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  // Counter only advances while a transaction is partially collected.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
    cnt_d      = '0;
`endif
    case (state_q)
      GET_A: if (i_rx_done) begin
        a_d     = i_data;
        state_d = GET_B;
      end
      GET_B: if (i_rx_done) begin
        b_d     = i_data;
        state_d = GET_OP;
      end
`ifdef ALU_IF_TIMEOUT_EN
      else if (tmo) begin
        err_d   = 1'b1;
        state_d = GET_A;
      end else cnt_d = cnt_q + 1'b1;
`endif
      GET_OP: if (i_rx_done) begin
        if (op_ok) begin
          tx_data_d  = alu_res;
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end else begin
          err_d   = 1'b1;
          state_d = GET_A;
        end
      end
`ifdef ALU_IF_TIMEOUT_EN
      else if (tmo) begin
        err_d   = 1'b1;
        state_d = GET_A;
      end else cnt_d = cnt_q + 1'b1;
`endif
      // Rx bytes arriving here are dropped, even alongside i_tx_done.
      WAIT_TX: if (i_tx_done) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == WAIT_TX);
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if: vector table for ALU ops plus hand-written protocol corner cases.
module tb_uart_alu_if;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_busy, o_err;

  int n_chk = 0;
  int n_pass = 0;

  uart_alu_if #(.NB_BITS(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a, b, op, exp;
    bit         ok;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [7:0] a, b, op, exp, input bit ok);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.exp = exp; v.ok = ok;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_data = b; i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clk);
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask

  // After the opcode strobe: check the start pulse and result, then release via i_tx_done.
  task automatic expect_result(input string name, input logic [7:0] exp);
    chk({name, " start"}, o_tx_start, 1);
    chk({name, " data"}, o_tx_data, exp);
    chk({name, " busy"}, o_busy, 1);
    @(negedge i_clk);
    chk({name, " start 1cyc"}, o_tx_start, 0);
    chk({name, " busy hold"}, o_busy, 1);
    tx_done_pulse();
    chk({name, " busy clr"}, o_busy, 0);
  endtask

  initial begin
    logic [7:0] last;
    int errs;

    add(8'h05, 8'h03, 8'h20, 8'h08, 1);
    add(8'h03, 8'h05, 8'h22, 8'hFE, 1);
    add(8'h80, 8'h02, 8'h03, 8'hE0, 1);
    add(8'h80, 8'h09, 8'h02, 8'h00, 1);
    add(8'hF0, 8'h0F, 8'h27, 8'h00, 1);
    add(8'h01, 8'h02, 8'h3F, 8'h00, 0);  // invalid: keeps 0x00
    add(8'h01, 8'h02, 8'h20, 8'h03, 1);
    add(8'hC5, 8'h3C, 8'h24, 8'h04, 1);
    add(8'hC5, 8'h3C, 8'h25, 8'hFD, 1);
    add(8'hC5, 8'h3C, 8'h26, 8'hF9, 1);
    add(8'h01, 8'h02, 8'h21, 8'hF9, 0);  // invalid: keeps 0xF9
    add(8'hFF, 8'h01, 8'h20, 8'h00, 1);
    add(8'h81, 8'h08, 8'h03, 8'hFF, 1);
    add(8'h81, 8'h07, 8'h03, 8'hFF, 1);
    add(8'h41, 8'hFF, 8'h03, 8'h00, 1);
    add(8'h81, 8'h01, 8'h02, 8'h40, 1);
    add(8'h81, 8'h07, 8'h02, 8'h01, 1);
    add(8'h01, 8'h02, 8'hE0, 8'h03, 1);  // upper opcode bits ignored
    add(8'h00, 8'h01, 8'h22, 8'hFF, 1);

    repeat (3) @(negedge i_clk);
    chk("rst data", o_tx_data, 0);
    chk("rst start", o_tx_start, 0);
    chk("rst busy", o_busy, 0);
    chk("rst err", o_err, 0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      rx_byte(vecs[i].a);
      rx_byte(vecs[i].b);
      chk({nm, " busy early"}, o_busy, 0);
      rx_byte(vecs[i].op);
      if (vecs[i].ok) begin
        chk({nm, " err"}, o_err, 0);
        expect_result(nm, vecs[i].exp);
      end else begin
        chk({nm, " err"}, o_err, 1);
        chk({nm, " no start"}, o_tx_start, 0);
        chk({nm, " data kept"}, o_tx_data, vecs[i].exp);
        chk({nm, " busy"}, o_busy, 0);
        @(negedge i_clk);
        chk({nm, " err 1cyc"}, o_err, 0);
      end
    end

    // Rx bytes during WAIT_TX are dropped, alone or alongside i_tx_done.
    rx_byte(8'h05); rx_byte(8'h03); rx_byte(8'h20);
    chk("wt start", o_tx_start, 1);
    rx_byte(8'h11);
    chk("wt busy", o_busy, 1);
    chk("wt err", o_err, 0);
    @(negedge i_clk);
    i_data = 8'h11; i_rx_done = 1'b1; i_tx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0; i_tx_done = 1'b0;
    chk("wt coinc busy", o_busy, 0);
    chk("wt coinc err", o_err, 0);
    rx_byte(8'h02);
    tx_done_pulse();  // ignored outside WAIT_TX
    chk("txdone idle busy", o_busy, 0);
    rx_byte(8'h02); rx_byte(8'h24);
    expect_result("wt after", 8'h02);

    // Synchronous reset drops a partial transaction.
    rx_byte(8'h07);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mid rst data", o_tx_data, 0);
    chk("mid rst start", o_tx_start, 0);
    chk("mid rst busy", o_busy, 0);
    chk("mid rst err", o_err, 0);
    i_rst = 1'b0;
    rx_byte(8'h01); rx_byte(8'h01); rx_byte(8'h20);
    expect_result("post rst", 8'h02);

    // Inter-byte idle gap.
    rx_byte(8'h09);
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_err) errs++;
    end
`ifdef ALU_IF_TIMEOUT_EN
    chk("tmo err pulses", errs, 1);
    rx_byte(8'h01); rx_byte(8'h01); rx_byte(8'h26);
    expect_result("tmo after", 8'h00);
`else
    chk("no tmo err", errs, 0);
    rx_byte(8'h01); rx_byte(8'h26);
    expect_result("no tmo result", 8'h08);
`endif

    last = o_tx_data;
    repeat (3) @(negedge i_clk);
    chk("idle data hold", o_tx_data, last);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
